// File: rtl/iobus_pkg.sv
// Shared definitions for the I/O bus initiator: default widths, the responder
// address map and the issue FSM encoding.
package iobus_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 32;

  localparam logic [7:0] ADDR_LEDS     = 8'h00;
  localparam logic [7:0] ADDR_SWITCHES = 8'h01;
  localparam logic [7:0] ADDR_VGAADDR  = 8'h02;
  localparam logic [7:0] ADDR_VGADATA  = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } iss_state_e;

  // Queue pointers carry one extra wrap bit above the entry index.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/iobus_req_fifo.sv
// Request queue holding {write, addr, wrdata}; head entry is presented
// combinationally from storage, full/empty come from the pointer wrap bit.
module iobus_req_fifo
  import iobus_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_write,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wrdata,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_head_write,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_wrdata
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned IW = PW - 1;

  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [DEPTH-1:0] r_write;
  logic [AW-1:0]  r_addr   [DEPTH];
  logic [DW-1:0]  r_wrdata [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                     (r_wptr[IW-1:0] == r_rptr[IW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_head_write  = r_write[r_rptr[IW-1:0]];
  assign o_head_addr   = r_addr[r_rptr[IW-1:0]];
  assign o_head_wrdata = r_wrdata[r_rptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_write[r_wptr[IW-1:0]]  <= i_write;
      r_addr[r_wptr[IW-1:0]]   <= i_addr;
      r_wrdata[r_wptr[IW-1:0]] <= i_wrdata;
    end
  end

endmodule

// File: rtl/iobus_master.sv
// Sole initiator on the 8-bit-address / 32-bit-data I/O bus: queues CPU
// loads/stores, drives stage-3a strobes and returns stage-4a read data in order.
//
// state     | meaning
// ST_IDLE   | no strobe this cycle
// ST_ISSUE  | exactly one strobe (read or write) this cycle
// ST_RDWAIT | read in flight, bus__rddata_4a captured at the end of this cycle
module iobus_master
  import iobus_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wrdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rddata,
  output logic          busy,
  output logic          bus__rdstrobe_3a,
  output logic          bus__wrstrobe_3a,
  output logic [AW-1:0] bus__address_3a,
  output logic [DW-1:0] bus__wrdata_3a,
  input  logic [DW-1:0] bus__rddata_4a
);

  iss_state_e    r_state;
  logic          r_rdstrobe;
  logic          r_wrstrobe;
  logic [AW-1:0] r_address;
  logic [DW-1:0] r_wrdata;
  logic          r_resp_valid;
  logic [DW-1:0] r_resp_rddata;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_head_write;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_wrdata;
  logic          w_rd_inflight;

  // No bypass: a full queue refuses even when the head pops this cycle.
  assign req_ready = !rst && !w_full;
  assign w_push    = req_valid && req_ready;

  iobus_req_fifo #(
    .DEPTH (QDEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_req_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_write       (req_write),
    .i_addr        (req_addr),
    .i_wrdata      (req_wrdata),
    .i_pop         (w_pop),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_head_write  (w_head_write),
    .o_head_addr   (w_head_addr),
    .o_head_wrdata (w_head_wrdata)
  );

  // Nothing issues behind an in-flight read, which keeps strict FIFO order;
  // a read additionally waits for the previous response to be consumed.
  assign w_rd_inflight = r_rdstrobe || (r_state == ST_RDWAIT);
  assign w_pop         = !w_empty && !w_rd_inflight &&
                         (w_head_write || !r_resp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rdstrobe    <= 1'b0;
      r_wrstrobe    <= 1'b0;
      r_address     <= '0;
      r_wrdata      <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_rddata <= '0;
    end else begin
      r_rdstrobe <= 1'b0;
      r_wrstrobe <= 1'b0;
      if (r_resp_valid && resp_ready) r_resp_valid <= 1'b0;

      case (r_state)
        ST_IDLE, ST_ISSUE: begin
          if (w_pop) begin
            r_state   <= ST_ISSUE;
            r_address <= w_head_addr;
            if (w_head_write) begin
              r_wrstrobe <= 1'b1;
              r_wrdata   <= w_head_wrdata;
            end else begin
              r_rdstrobe <= 1'b1;
            end
          end else if (r_rdstrobe) begin
            r_state <= ST_RDWAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RDWAIT: begin
          r_resp_valid  <= 1'b1;
          r_resp_rddata <= bus__rddata_4a;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus__rdstrobe_3a = r_rdstrobe;
  assign bus__wrstrobe_3a = r_wrstrobe;
  assign bus__address_3a  = r_address;
  assign bus__wrdata_3a   = r_wrdata;
  assign resp_valid       = r_resp_valid;
  assign resp_rddata      = r_resp_rddata;
  assign busy             = !w_empty || w_rd_inflight || r_resp_valid;

  a_one_strobe: assert property (@(posedge clk) !(r_rdstrobe && r_wrstrobe));

endmodule

// File: tb/tb_iobus_master.sv
// Directed bench for iobus_master with a registered responder model that
// returns data only in the cycle after a read strobe.
module tb_iobus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wrdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rddata;
  logic        busy;
  logic        rdstrobe;
  logic        wrstrobe;
  logic [7:0]  address;
  logic [31:0] wrdata;
  logic [31:0] rddata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int          rd_cyc[$];
  logic [7:0]  rd_addr[$];
  int          wr_cyc[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          rsp_cyc[$];
  logic [31:0] rsp_data[$];
  int          both_cnt = 0;

  iobus_master #(.QDEPTH(2), .AW(8), .DW(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wrdata       (req_wrdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rddata      (resp_rddata),
    .busy             (busy),
    .bus__rdstrobe_3a (rdstrobe),
    .bus__wrstrobe_3a (wrstrobe),
    .bus__address_3a  (address),
    .bus__wrdata_3a   (wrdata),
    .bus__rddata_4a   (rddata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rsp_fn(input logic [7:0] a);
    return (a == 8'h01) ? 32'h0000_003C : {16'hC0DE, 8'h00, a};
  endfunction

  always @(posedge clk) rddata <= rdstrobe ? rsp_fn(address) : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    if (rdstrobe) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(address);
    end
    if (wrstrobe) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(address);
      wr_data.push_back(wrdata);
    end
    if (rdstrobe && wrstrobe) both_cnt <= both_cnt + 1;
    if (resp_valid && resp_ready) begin
      rsp_cyc.push_back(cyc);
      rsp_data.push_back(resp_rddata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic wr, input logic [7:0] a, input logic [31:0] d, output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_wrdata = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      stalls++;
    end
    if (!acc) check_eq("push_timeout", 32'(acc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp_valid(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check_eq("resp_timeout", 32'd0, 32'd1);
  endtask

  int s;
  int s4;
  int t;
  int rb, wb, sb;
  logic seen;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wrdata = '0;
    resp_ready = 1'b1;

    // reset state
    step(3);
    @(negedge clk);
    check_eq("rst_ready",   32'(req_ready), 32'd0);
    check_eq("rst_rdstb",   32'(rdstrobe), 32'd0);
    check_eq("rst_wrstb",   32'(wrstrobe), 32'd0);
    check_eq("rst_addr",    32'(address), 32'd0);
    check_eq("rst_wrdata",  wrdata, 32'd0);
    check_eq("rst_rvalid",  32'(resp_valid), 32'd0);
    check_eq("rst_rdata",   resp_rddata, 32'd0);
    check_eq("rst_busy",    32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);
    step(1);

    // single write
    rb = rd_cyc.size(); wb = wr_cyc.size(); sb = rsp_cyc.size();
    push(1'b1, 8'h00, 32'h0000_00A5, s);
    step(6);
    check_eq("w1_count",  32'(wr_cyc.size() - wb), 32'd1);
    check_eq("w1_addr",   32'(wr_addr[wb]), 32'h00);
    check_eq("w1_data",   wr_data[wb], 32'h0000_00A5);
    check_eq("w1_no_rd",  32'(rd_cyc.size() - rb), 32'd0);
    check_eq("w1_no_rsp", 32'(rsp_cyc.size() - sb), 32'd0);
    check_eq("w1_busy",   32'(busy), 32'd0);
    check_eq("w1_hold",   wrdata, 32'h0000_00A5);

    // three back-to-back writes
    wb = wr_cyc.size();
    push(1'b1, 8'h02, 32'h0000_0011, s);
    push(1'b1, 8'h03, 32'h0000_0022, s);
    push(1'b1, 8'h00, 32'h0000_0033, s);
    step(8);
    check_eq("w3_count", 32'(wr_cyc.size() - wb), 32'd3);
    check_eq("w3_a0", 32'(wr_addr[wb]),   32'h02);
    check_eq("w3_d0", wr_data[wb],        32'h11);
    check_eq("w3_a1", 32'(wr_addr[wb+1]), 32'h03);
    check_eq("w3_d1", wr_data[wb+1],      32'h22);
    check_eq("w3_a2", 32'(wr_addr[wb+2]), 32'h00);
    check_eq("w3_d2", wr_data[wb+2],      32'h33);
    check_eq("w3_gap01", 32'(wr_cyc[wb+1] - wr_cyc[wb]),   32'd1);
    check_eq("w3_gap12", 32'(wr_cyc[wb+2] - wr_cyc[wb+1]), 32'd1);

    // single read, data only valid in N+1
    rb = rd_cyc.size(); sb = rsp_cyc.size();
    push(1'b0, 8'h01, 32'h0, s);
    wait_resp_valid(20, t);
    check_eq("r1_count", 32'(rd_cyc.size() - rb), 32'd1);
    check_eq("r1_addr",  32'(rd_addr[rb]), 32'h01);
    check_eq("r1_lat",   32'(t - rd_cyc[rb]), 32'd2);
    check_eq("r1_data",  resp_rddata, 32'h0000_003C);
    step(4);
    check_eq("r1_clear", 32'(resp_valid), 32'd0);

    // two reads and two writes with the response stalled
    resp_ready = 1'b0;
    rb = rd_cyc.size(); wb = wr_cyc.size(); sb = rsp_cyc.size();
    fork
      begin
        push(1'b0, 8'h02, 32'h0, s);
        push(1'b0, 8'h03, 32'h0, s);
        push(1'b1, 8'h00, 32'h0000_0055, s);
        push(1'b1, 8'h01, 32'h0000_0066, s4);
      end
      begin
        wait_resp_valid(40, t);
        repeat (5) @(negedge clk);
        check_eq("rr_hold_v", 32'(resp_valid), 32'd1);
        check_eq("rr_hold_d", resp_rddata, rsp_fn(8'h02));
        check_eq("rr_no_rd2", 32'(rd_cyc.size() - rb), 32'd1);
        @(posedge clk); #1;
        resp_ready = 1'b1;
      end
    join
    step(20);
    check_eq("rr_rd_count", 32'(rd_cyc.size() - rb), 32'd2);
    check_eq("rr_a0",       32'(rd_addr[rb]),   32'h02);
    check_eq("rr_a1",       32'(rd_addr[rb+1]), 32'h03);
    check_eq("rr_rd2_time", 32'(rd_cyc[rb+1] - rsp_cyc[sb]), 32'd2);
    check_eq("rr_rsp_count", 32'(rsp_cyc.size() - sb), 32'd2);
    check_eq("rr_d0", rsp_data[sb],   rsp_fn(8'h02));
    check_eq("rr_d1", rsp_data[sb+1], rsp_fn(8'h03));
    check_eq("rr_wr_count", 32'(wr_cyc.size() - wb), 32'd2);
    check_eq("rr_wr_after", 32'(wr_cyc[wb] > rd_cyc[rb+1]), 32'd1);
    check_eq("rr_full_stall", 32'(s4 > 0), 32'd1);

    // read then write
    rb = rd_cyc.size(); wb = wr_cyc.size(); sb = rsp_cyc.size();
    push(1'b0, 8'h01, 32'h0, s);
    push(1'b1, 8'h02, 32'h0000_0077, s);
    step(15);
    check_eq("rw_rd_count", 32'(rd_cyc.size() - rb), 32'd1);
    check_eq("rw_wr_count", 32'(wr_cyc.size() - wb), 32'd1);
    check_eq("rw_order",    32'(wr_cyc[wb] > rd_cyc[rb]), 32'd1);
    check_eq("rw_wr_data",  wr_data[wb], 32'h0000_0077);
    check_eq("rw_rsp",      rsp_data[sb], 32'h0000_003C);

    // reset in the cycle after rdstrobe
    rb = rd_cyc.size(); wb = wr_cyc.size(); sb = rsp_cyc.size();
    push(1'b0, 8'h01, 32'h0, s);
    push(1'b1, 8'h03, 32'h0000_0099, s);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdstrobe) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("mr_rdstb_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mr_ready_in_rst", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mr_rdstb_drop", 32'(rdstrobe), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(8);
    check_eq("mr_no_rsp",   32'(rsp_cyc.size() - sb), 32'd0);
    check_eq("mr_no_wr",    32'(wr_cyc.size() - wb), 32'd0);
    check_eq("mr_rd_once",  32'(rd_cyc.size() - rb), 32'd1);
    check_eq("mr_busy",     32'(busy), 32'd0);
    check_eq("mr_ready",    32'(req_ready), 32'd1);

    check_eq("never_both", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
